// File: rtl/div_pkg.sv
// Shared definitions for the divided-clock generator/monitor family.
package div_pkg;

   // Monitor tracking state.
   typedef enum logic [1:0] {
      StIdle,
      StMeas,
      StLocked
   } div_state_e;

   // Cycles without a rising edge before the divided clock is declared stuck.
   function automatic int unsigned timeout_cycles(input int unsigned div_exp);
      return 2 * div_exp;
   endfunction

   // True when a cnt_w-bit saturating counter can reach the timeout value.
   function automatic bit cnt_w_ok(input int unsigned cnt_w, input int unsigned div_exp);
      return ((64'd1 << cnt_w) - 64'd1) >= 64'(timeout_cycles(div_exp));
   endfunction

endpackage

// File: rtl/div_clk_monitor_if.sv
// Divided-clock input and measurement/status outputs of the monitor.
interface div_clk_monitor_if #(
   parameter int unsigned CNT_W = 8
);
   logic             clk_div;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             meas_valid;
   logic             locked;
   logic             err;
   logic             stuck;

   // Source side: drives the divided clock, observes the verdict.
   modport master (
      output clk_div,
      input  period, high_time, meas_valid, locked, err, stuck
   );

   // Monitor side.
   modport slave (
      input  clk_div,
      output period, high_time, meas_valid, locked, err, stuck
   );
endinterface

// File: rtl/sync_edge_det.sv
// Registers a signal synchronous to clk_i and flags its rising/falling edges.
module sync_edge_det #(
   parameter bit ResetVal = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);

   logic s_q;

   // Previous-cycle sample; the reset value decides whether a level present at
   // reset release counts as an edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s_q <= ResetVal;
      end else begin
         s_q <= d_i;
      end
   end

   assign rise_o = d_i & ~s_q;
   assign fall_o = ~d_i & s_q;

endmodule

// File: rtl/div_clk_monitor.sv
// Measures period and high time of a divided clock in clk_i cycles and reports
// lock, mismatch and stuck conditions against the expected ratio.
module div_clk_monitor
   import div_pkg::*;
#(
   parameter int unsigned DIV_EXP  = 8,
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned LOCK_CNT = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   div_clk_monitor_if.slave   mon_if
);

   localparam bit                CntWLegal = cnt_w_ok(CNT_W, DIV_EXP);
   localparam logic [CNT_W-1:0]  CntMax    = '1;
   localparam logic [CNT_W-1:0]  DivExp    = CNT_W'(DIV_EXP);
   localparam logic [CNT_W-1:0]  TimeoutM1 = CNT_W'(timeout_cycles(DIV_EXP) - 1);
   // Accepted window for 2*high_time: DIV_EXP-1 .. DIV_EXP+1.
   localparam logic [CNT_W:0]    DutyLo    = (CNT_W + 1)'(DIV_EXP - 1);
   localparam logic [CNT_W:0]    DutyHi    = (CNT_W + 1)'(DIV_EXP + 1);
   localparam int unsigned       GoodW     = $clog2(LOCK_CNT + 1);
   localparam logic [GoodW-1:0]  LockCnt   = GoodW'(LOCK_CNT);

   if (!CntWLegal || DIV_EXP < 2 || LOCK_CNT < 1) begin : g_param_check
      $error("div_clk_monitor: illegal DIV_EXP/CNT_W/LOCK_CNT combination");
   end

   logic             rise, fall;
   logic             good, timeout;
   logic [CNT_W:0]   hi_x2;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hi_q, hi_d;
   logic [GoodW-1:0] good_cnt_q, good_cnt_d;
   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic             meas_valid_q, meas_valid_d;
   logic             locked_q, locked_d;
   logic             err_q, err_d;
   logic             stuck_q, stuck_d;

   sync_edge_det #(
      .ResetVal (1'b1)
   ) u_edge (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .d_i    (mon_if.clk_div),
      .rise_o (rise),
      .fall_o (fall)
   );

   // Cycle counter restarted by each rise; captures high time on each fall.
   always_comb begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
      if (rise) begin
         cnt_d = CNT_W'(1);
      end
      hi_d = hi_q;
      if (fall && state_q != StIdle) begin
         hi_d = cnt_q;
      end
   end

   assign hi_x2   = {hi_q, 1'b0};
   assign good    = (cnt_q == DivExp) && (hi_x2 >= DutyLo) && (hi_x2 <= DutyHi);
   // Fires on the edge where cnt would reach the timeout; a rise takes priority.
   assign timeout = !rise && (cnt_q == TimeoutM1);

   // Tracking FSM plus measurement/status next-state.
   always_comb begin
      state_d      = state_q;
      good_cnt_d   = good_cnt_q;
      period_d     = period_q;
      high_d       = high_q;
      meas_valid_d = 1'b0;
      locked_d     = locked_q;
      err_d        = 1'b0;
      stuck_d      = stuck_q;

      if (rise) begin
         stuck_d = 1'b0;
         case (state_q)
            StIdle: begin
               // First rise only opens a measurement window.
               state_d    = StMeas;
               good_cnt_d = '0;
            end
            StMeas: begin
               period_d     = cnt_q;
               high_d       = hi_q;
               meas_valid_d = 1'b1;
               if (good) begin
                  good_cnt_d = good_cnt_q + 1'b1;
                  if (good_cnt_d == LockCnt) begin
                     state_d  = StLocked;
                     locked_d = 1'b1;
                  end
               end else begin
                  good_cnt_d = '0;
               end
            end
            StLocked: begin
               period_d     = cnt_q;
               high_d       = hi_q;
               meas_valid_d = 1'b1;
               if (!good) begin
                  err_d      = 1'b1;
                  locked_d   = 1'b0;
                  state_d    = StMeas;
                  good_cnt_d = '0;
               end
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end else if (timeout) begin
         stuck_d  = 1'b1;
         locked_d = 1'b0;
         err_d    = (state_q != StIdle);
         state_d  = StIdle;
      end
   end

   // State and output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q        <= '0;
         hi_q         <= '0;
         good_cnt_q   <= '0;
         state_q      <= StIdle;
         period_q     <= '0;
         high_q       <= '0;
         meas_valid_q <= 1'b0;
         locked_q     <= 1'b0;
         err_q        <= 1'b0;
         stuck_q      <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         hi_q         <= hi_d;
         good_cnt_q   <= good_cnt_d;
         state_q      <= state_d;
         period_q     <= period_d;
         high_q       <= high_d;
         meas_valid_q <= meas_valid_d;
         locked_q     <= locked_d;
         err_q        <= err_d;
         stuck_q      <= stuck_d;
      end
   end

   assign mon_if.period     = period_q;
   assign mon_if.high_time  = high_q;
   assign mon_if.meas_valid = meas_valid_q;
   assign mon_if.locked     = locked_q;
   assign mon_if.err        = err_q;
   assign mon_if.stuck      = stuck_q;

endmodule

// File: doc/div_clk_monitor.md
# div_clk_monitor

Checks a divided clock that was produced from the system clock. The block samples the divided clock as a synchronous data signal on `clk`. It measures the period and high time in `clk` cycles and compares them against the expected division ratio. It reports lock, mismatch errors and a stuck/absent divided clock. It sits on the consumer side of the clock-divider blocks (for example, their `clk_8`-style outputs) as a self-check and bring-up monitor.

## Interface
- `DIV_EXP`, default 8: expected division ratio, ≥2.
- `CNT_W`, default 8: measurement counter width; must satisfy 2^CNT_W−1 ≥ 2·DIV_EXP.
- `LOCK_CNT`, default 4: consecutive good periods required for lock, ≥1.
- `clk` (input, 1): system clock; the divided clock is derived from it.
- `rst` (input, 1): reset, synchronous and active-high, one clock domain.
- `clk_div` (input, 1): divided clock under test, synchronous to `clk`.
- `period` (output, CNT_W): last measured period, in `clk` cycles.
- `high_time` (output, CNT_W): last measured high time, in `clk` cycles.
- `meas_valid` (output, 1): one-cycle pulse when `period`/`high_time` update.
- `locked` (output, 1): level; asserted after LOCK_CNT consecutive good periods.
- `err` (output, 1): one-cycle pulse on a bad period while locked, or on a timeout.
- `stuck` (output, 1): level; no rising edge for TIMEOUT cycles.

## Operation
- Edge detection:
  - `s_q <= clk_div` every cycle; `s_q` resets to 1, so a high input at reset release is not a rise.
  - rise = `clk_div & ~s_q`; fall = `~clk_div & s_q`.
- Counter `cnt`:
  - On a rise, `cnt <= 1`.
  - Otherwise `cnt` increments, saturating at 2^CNT_W−1.
  - Consequence: `cnt` at a rise equals the period; `cnt` at a fall equals the high time.
- On a fall: `hi_r <= cnt`. A fall in IDLE is ignored.
- Good period: `cnt == DIV_EXP` at the rise AND |2·hi_r − DIV_EXP| ≤ 1.
- FSM states IDLE, MEAS, LOCKED:
  - IDLE:
    - First rise → MEAS; `good_cnt <= 0`.
    - No `period`/`high_time` update and no `meas_valid` pulse.
  - MEAS, on each rise:
    - `period <= cnt`, `high_time <= hi_r`, `meas_valid <= 1`.
    - Good: increment `good_cnt`. On reaching LOCK_CNT → LOCKED and `locked <= 1`.
    - Bad: `good_cnt <= 0`, stay in MEAS, no `err`.
  - LOCKED, on each rise:
    - Same update and `meas_valid` pulse as MEAS.
    - Bad: `err` pulse, `locked <= 0`, → MEAS, `good_cnt <= 0`.
  - Timeout, when `cnt == TIMEOUT` with no rise in that cycle (TIMEOUT = 2·DIV_EXP):
    - `stuck <= 1`, state → IDLE, `locked <= 0`.
    - `err` pulses only if the state was MEAS or LOCKED.
    - `stuck` clears on the next rise.
- A rise and a timeout in the same cycle: the rise wins; no timeout is raised.
- `rst` mid-operation:
  - All state returns to reset values on the next edge.
  - A measurement in progress is discarded.
  - The first post-reset rise only starts a new measurement.

## Timing
- Reset values:
  - Outputs: `period`=0, `high_time`=0, `meas_valid`=0, `locked`=0, `err`=0, `stuck`=0.
  - Internal: `cnt`=0, `hi_r`=0, `good_cnt`=0, state IDLE, `s_q`=1.
- Latency:
  - A rise seen at edge k (`clk_div`=1, `s_q`=0) gives updated `period` and `meas_valid`=1 in the cycle after edge k.
  - `locked` and `err` change on the same edge as that `meas_valid`.
- Time to lock: `locked` first rises in the cycle after the (LOCK_CNT+1)-th rising edge from IDLE.
- Time to `stuck`: `stuck` and timeout `err` assert TIMEOUT−1 edges after the last rise (`cnt` runs from 1 up to TIMEOUT).
- `meas_valid` and `err` are single-cycle pulses and are never stretched.

## Structure
- Shared package `div_pkg`:
  - state enum {IDLE, MEAS, LOCKED};
  - function computing TIMEOUT from DIV_EXP;
  - CNT_W legality check constant.
  - The clock-divider blocks reuse it.
- One natural sub-module: `sync_edge_det` (the `s_q` register with its reset value as a parameter, plus rise/fall outputs).
- The remainder (counter, capture registers, FSM) stays in `div_clk_monitor`.

## Test plan
- Ideal `clk_8`-style input (4 high, 4 low), defaults:
  - `meas_valid` pulses every 8 cycles with `period`=8, `high_time`=4;
  - `locked`=1 after the 5th rise; no `err`.
- Locked, then a single 10-cycle period (6 high):
  - `period`=10, one `err` pulse, `locked` 1→0;
  - relocks after 4 further good periods.
- Duty fault at correct period (period 8, 2 high): counted bad; `locked` is never asserted; no `err` while in MEAS.
- `clk_div` held low after lock:
  - `stuck`=1 and one `err` pulse 15 cycles after the last rise; `locked`=0;
  - restoring the clock clears `stuck` at the first rise, and no measurement is reported for that rise.
- `clk_div`=1 during and after reset release: no rise is detected until after the first low.
- `rst` asserted for 1 cycle mid-period while locked:
  - all outputs return to 0;
  - the first subsequent rise produces no `meas_valid`.
